dsp_route_sum: RTL and testbench



---
 rtl/dsp_route_sum.sv | 162 ++++++++++++++++
 tb/tb_dsp_route_sum.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dsp_route_sum.sv
// dsp_route_sum: routes SRC masked, shift-attenuated sources through a pipelined adder tree into OUTS saturating outputs; define DSP_ROUTE_SHADOW_EN for shadowed config with commit
module dsp_route_sum #(
  parameter int SRC     = 16,
  parameter int OUTS    = 2,
  parameter int DW      = 14,
  parameter int LOG_SRC = 4,
  parameter int SHW     = 3
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic [SRC*DW-1:0]    src_dat_i,
  output logic [OUTS*DW-1:0]   out_dat_o,
  output logic [OUTS-1:0]      sat_o,
  input  logic [15:0]          sys_addr,
  input  logic [31:0]          sys_wdata,
  input  logic                 sys_wen,
  input  logic                 sys_ren,
  output logic [31:0]          sys_rdata,
  output logic                 sys_ack,
  output logic                 sys_err
);
  localparam int TW = DW + LOG_SRC;
  localparam int N = 1 << LOG_SRC;
  localparam logic signed [TW-1:0] MAXV = TW'((1 << (DW-1)) - 1);
  localparam logic signed [TW-1:0] MINV = TW'(-(1 << (DW-1)));
  logic [OUTS-1:0] act_msk [SRC];
  logic [SHW-1:0]  act_sh  [SRC];
`ifdef DSP_ROUTE_SHADOW_EN
  logic [OUTS-1:0] shd_msk [SRC];
  logic [SHW-1:0]  shd_sh  [SRC];
  logic            commit;
`endif
  logic [OUTS-1:0]      sticky;
  logic [OUTS-1:0]      clr;
  logic [SRC-1:0]       sel_cfg;
  logic                 hit;
  logic [31:0]          rd_val;
  logic signed [TW-1:0] root [OUTS];
  logic                 unused_wdata;
  assign unused_wdata = ^sys_wdata;
  function automatic logic [31:0] cfg_word(input logic [OUTS-1:0] m, input logic [SHW-1:0] sh);
    logic [31:0] w;
    w = '0;
    w[OUTS-1:0] = m;
    w[8 +: SHW] = sh;
    return w;
  endfunction
  function automatic logic signed [TW-1:0] term(input logic [DW-1:0] x, input logic [SHW-1:0] sh);
    logic signed [TW-1:0] e;
    e = TW'($signed(x));
    return e >>> sh;
  endfunction
  assign clr = (sys_wen && sys_addr == 16'h100) ? sys_wdata[OUTS-1:0] : '0;
`ifdef DSP_ROUTE_SHADOW_EN
  assign commit = sys_wen && sys_addr == 16'h104 && sys_wdata[0];
`endif
  // address decode and read mux; anything not matched is an error access
  always_comb begin
    sel_cfg = '0;
    hit = 1'b0;
    rd_val = '0;
    for (int s = 0; s < SRC; s++) begin
      if (sys_addr == 16'(4*s)) begin
        sel_cfg[s] = 1'b1;
        hit = 1'b1;
`ifdef DSP_ROUTE_SHADOW_EN
        rd_val = cfg_word(shd_msk[s], shd_sh[s]);
`else
        rd_val = cfg_word(act_msk[s], act_sh[s]);
`endif
      end
`ifdef DSP_ROUTE_SHADOW_EN
      if (sys_addr == 16'(16'h200 + 4*s)) begin
        hit = 1'b1;
        rd_val = cfg_word(act_msk[s], act_sh[s]);
      end
`endif
    end
    if (sys_addr == 16'h100) begin
      hit = 1'b1;
      rd_val = 32'(sticky);
    end
    if (sys_addr == 16'h108) begin
      hit = 1'b1;
      rd_val = 32'(LOG_SRC + 2);
    end
`ifdef DSP_ROUTE_SHADOW_EN
    if (sys_addr == 16'h104) hit = 1'b1;
`endif
  end
  // config storage: direct writes, or shadow writes copied over on commit
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int s = 0; s < SRC; s++) begin
        act_msk[s] <= '0;
        act_sh[s] <= '0;
`ifdef DSP_ROUTE_SHADOW_EN
        shd_msk[s] <= '0;
        shd_sh[s] <= '0;
`endif
      end
    end else begin
      for (int s = 0; s < SRC; s++) begin
`ifdef DSP_ROUTE_SHADOW_EN
        if (sys_wen && sel_cfg[s]) begin
          shd_msk[s] <= sys_wdata[OUTS-1:0];
          shd_sh[s] <= sys_wdata[8 +: SHW];
        end
        if (commit) begin
          act_msk[s] <= shd_msk[s];
          act_sh[s] <= shd_sh[s];
        end
`else
        if (sys_wen && sel_cfg[s]) begin
          act_msk[s] <= sys_wdata[OUTS-1:0];
          act_sh[s] <= sys_wdata[8 +: SHW];
        end
`endif
      end
    end
  end
  // bus response one cycle after the strobe, plus sticky overflow with set winning over clear
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sys_ack <= 1'b0;
      sys_err <= 1'b0;
      sys_rdata <= '0;
      sticky <= '0;
    end else begin
      sys_ack <= sys_wen | sys_ren;
      sys_err <= (sys_wen | sys_ren) & ~hit;
      sys_rdata <= (sys_ren && hit) ? rd_val : '0;
      sticky <= (sticky & ~clr) | sat_o;
    end
  end
  for (genvar k = 0; k < OUTS; k++) begin : g_out
    logic signed [TW-1:0] nd [1:2*N-1];
    // heap-ordered tree: leaves N..2N-1 are stage-1 terms, each inner level is one pipeline stage
    always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
        for (int j = 1; j < 2*N; j++) nd[j] <= '0;
      end else begin
        for (int j = 1; j < N; j++) nd[j] <= nd[2*j] + nd[2*j+1];
        for (int s = 0; s < SRC; s++) nd[N+s] <= act_msk[s][k] ? term(src_dat_i[s*DW +: DW], act_sh[s]) : '0;
        for (int s = SRC; s < N; s++) nd[N+s] <= '0;
      end
    end
    assign root[k] = nd[1];
  end
  // clamp each tree sum to the sample range and flag clipping alongside it
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_dat_o <= '0;
      sat_o <= '0;
    end else begin
      for (int k = 0; k < OUTS; k++) begin
        out_dat_o[k*DW +: DW] <= root[k] > MAXV ? MAXV[DW-1:0] : root[k] < MINV ? MINV[DW-1:0] : root[k][DW-1:0];
        sat_o[k] <= root[k] > MAXV || root[k] < MINV;
      end
    end
  end
endmodule

// File: tb/tb_dsp_route_sum.sv
// tb_dsp_route_sum: directed and random checks of dsp_route_sum against a cycle-level mixing model
module tb_dsp_route_sum;
  localparam int SRC = 16, OUTS = 2, DW = 14, LOG_SRC = 4, SHW = 3, LAT = LOG_SRC + 2;
  localparam int MX = (1 << (DW-1)) - 1;
  typedef struct packed { logic [OUTS-1:0] s; logic [OUTS-1:0][31:0] o; } exp_t;
  logic clk_i = 1'b0;
  logic rstn_i = 1'b0;
  logic [SRC*DW-1:0] src_dat_i = '0;
  logic [OUTS*DW-1:0] out_dat_o;
  logic [OUTS-1:0] sat_o;
  logic [15:0] sys_addr = '0;
  logic [31:0] sys_wdata = '0;
  logic sys_wen = 1'b0;
  logic sys_ren = 1'b0;
  logic [31:0] sys_rdata;
  logic sys_ack, sys_err;
  int checks = 0, errors = 0;
  logic [OUTS-1:0] am [SRC];
  int ash [SRC];
  logic [OUTS-1:0] sm [SRC];
  int ssh [SRC];
  logic [OUTS-1:0] sticky_m;
  exp_t cur;
  exp_t q[$];
  logic [31:0] rdv;
  logic rde;
  int want, amp;
  always #5 clk_i = ~clk_i;
  dsp_route_sum #(.SRC(SRC), .OUTS(OUTS), .DW(DW), .LOG_SRC(LOG_SRC), .SHW(SHW)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .src_dat_i(src_dat_i), .out_dat_o(out_dat_o), .sat_o(sat_o),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_wen(sys_wen), .sys_ren(sys_ren),
    .sys_rdata(sys_rdata), .sys_ack(sys_ack), .sys_err(sys_err)
  );
  function automatic int src_val(int s);
    return int'($signed(src_dat_i[s*DW +: DW]));
  endfunction
  function automatic int outv(int k);
    return int'($signed(out_dat_o[k*DW +: DW]));
  endfunction
  function automatic exp_t mix();
    exp_t r;
    int acc;
    r = '0;
    for (int k = 0; k < OUTS; k++) begin
      acc = 0;
      for (int s = 0; s < SRC; s++) if (am[s][k]) acc += src_val(s) >>> ash[s];
      r.s[k] = acc > MX || acc < -MX - 1;
      r.o[k] = acc > MX ? MX : acc < -MX - 1 ? -MX - 1 : acc;
    end
    return r;
  endfunction
  task automatic model_reset();
    for (int s = 0; s < SRC; s++) begin
      am[s] = '0; ash[s] = 0; sm[s] = '0; ssh[s] = 0;
    end
    sticky_m = '0;
    q.delete();
    for (int i = 0; i < LAT - 1; i++) q.push_back('0);
    cur = '0;
  endtask
  task automatic model_write(logic [15:0] a, logic [31:0] w);
    if (a[1:0] == 2'b00 && int'(a) < 4*SRC) begin
`ifdef DSP_ROUTE_SHADOW_EN
      sm[a >> 2] = w[OUTS-1:0];
      ssh[a >> 2] = int'(w[8 +: SHW]);
`else
      am[a >> 2] = w[OUTS-1:0];
      ash[a >> 2] = int'(w[8 +: SHW]);
`endif
    end
`ifdef DSP_ROUTE_SHADOW_EN
    if (a == 16'h104 && w[0]) for (int s = 0; s < SRC; s++) begin
      am[s] = sm[s];
      ash[s] = ssh[s];
    end
`endif
  endtask
  task automatic tick();
    exp_t e;
    logic [OUTS-1:0] clr;
    e = mix();
    clr = (sys_wen && sys_addr == 16'h100) ? sys_wdata[OUTS-1:0] : '0;
    sticky_m = (sticky_m & ~clr) | cur.s;
    q.push_back(e);
    cur = q.pop_front();
    if (sys_wen) model_write(sys_addr, sys_wdata);
    @(posedge clk_i);
    @(negedge clk_i);
  endtask
  task automatic chk(string tag, int obs, int exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: got %0d want %0d", tag, obs, exp_v);
    end
  endtask
  task automatic chk_out(string tag);
    for (int k = 0; k < OUTS; k++) chk(tag, outv(k), int'(cur.o[k]));
    chk({tag, "_sat"}, int'(sat_o), int'(cur.s));
  endtask
  task automatic set_src(int s, int v);
    src_dat_i[s*DW +: DW] = DW'(v);
  endtask
  task automatic wr(logic [15:0] a, logic [31:0] w);
    sys_addr = a; sys_wdata = w; sys_wen = 1'b1;
    tick();
    sys_wen = 1'b0;
    chk("wr_ack", int'(sys_ack), 1);
  endtask
  task automatic rd(logic [15:0] a, output logic [31:0] d, output logic e);
    sys_addr = a; sys_ren = 1'b1;
    tick();
    sys_ren = 1'b0;
    chk("rd_ack", int'(sys_ack), 1);
    d = sys_rdata;
    e = sys_err;
  endtask
  task automatic cfg(int s, logic [31:0] w);
    wr(16'(4*s), w);
`ifdef DSP_ROUTE_SHADOW_EN
    wr(16'h104, 32'h1);
`endif
  endtask
  initial begin
    model_reset();
    #12 rstn_i = 1'b1;
    @(negedge clk_i);
    chk("rst_out0", outv(0), 0);
    chk("rst_out1", outv(1), 0);
    chk("rst_sat", int'(sat_o), 0);
    chk("rst_ack", int'(sys_ack), 0);
    chk("rst_err", int'(sys_err), 0);
    chk("rst_rdata", int'(sys_rdata), 0);
    cfg(0, 32'h001);
    set_src(0, 1000);
    for (int i = 1; i < LAT; i++) begin
      tick();
      chk("lat_early", outv(0), 0);
    end
    tick();
    chk("route_out0", outv(0), 1000);
    chk("route_out1", outv(1), 0);
    chk_out("route_model");
    cfg(0, 32'h003);
    repeat (LAT) tick();
    chk("route_both0", outv(0), 1000);
    chk("route_both1", outv(1), 1000);
    cfg(0, 32'h0);
    set_src(0, 0);
    cfg(2, 32'h201);
    set_src(2, -1001);
    repeat (LAT) tick();
    chk("shift_neg", outv(0), -251);
    set_src(2, 1001);
    repeat (LAT) tick();
    chk("shift_pos", outv(0), 250);
    chk_out("shift_model");
    cfg(2, 32'h0);
    set_src(2, 0);
    cfg(0, 32'h1);
    cfg(1, 32'h1);
    set_src(0, 8000);
    set_src(1, 8000);
    repeat (LAT) tick();
    chk("sat_out0", outv(0), 8191);
    chk("sat_flag0", int'(sat_o[0]), 1);
    tick();
    rd(16'h100, rdv, rde);
    chk("sticky_set", int'(rdv), 1);
    wr(16'h100, 32'h1);
    rd(16'h100, rdv, rde);
    chk("sticky_set_wins", int'(rdv), 1);
    set_src(1, 0);
    repeat (LAT) tick();
    chk("unsat_out0", outv(0), 8000);
    chk("unsat_flag", int'(sat_o), 0);
    wr(16'h100, 32'h1);
    rd(16'h100, rdv, rde);
    chk("sticky_clr", int'(rdv), 0);
    cfg(0, 32'h2);
    cfg(1, 32'h2);
    cfg(2, 32'h2);
    for (int s = 0; s < 3; s++) set_src(s, -8192);
    repeat (LAT) tick();
    chk("negsat_out1", outv(1), -8192);
    chk("negsat_flag1", int'(sat_o[1]), 1);
    chk("negsat_out0", outv(0), 0);
    chk_out("negsat_model");
    rd(16'h3FC, rdv, rde);
    chk("unmapped_err", int'(rde), 1);
    chk("unmapped_rdata", int'(rdv), 0);
    tick();
    chk("ack_pulse", int'(sys_ack), 0);
    rd(16'h108, rdv, rde);
    chk("latency_reg", int'(rdv), LAT);
    chk("latency_err", int'(rde), 0);
    wr(16'h040, 32'hFFFF);
    chk("cfg_oob_err", int'(sys_err), 1);
    rd(16'h000, rdv, rde);
    chk("cfg0_rd", int'(rdv), 2);
    wr(16'h00C, 32'hFFFFFFFF);
    rd(16'h00C, rdv, rde);
    chk("cfg_unused_bits", int'(rdv), 32'h703);
    rd(16'h104, rdv, rde);
`ifdef DSP_ROUTE_SHADOW_EN
    chk("commit_rd_err", int'(rde), 0);
    rd(16'h200, rdv, rde);
    chk("act_rd", int'(rdv), 2);
`else
    chk("commit_rd_err", int'(rde), 1);
    rd(16'h200, rdv, rde);
    chk("act_rd_err", int'(rde), 1);
`endif
    for (int s = 1; s < SRC; s++) cfg(s, 32'h0);
    for (int s = 1; s < SRC; s++) set_src(s, 0);
    cfg(0, 32'h1);
    set_src(0, 5000);
    repeat (LAT) tick();
    chk("pre_rst_out0", outv(0), 5000);
    #2 rstn_i = 1'b0;
    #1;
    chk("async_rst_out0", outv(0), 0);
    chk("async_rst_sat", int'(sat_o), 0);
    model_reset();
    @(negedge clk_i);
    rstn_i = 1'b1;
    rd(16'h000, rdv, rde);
    chk("rst_cfg0", int'(rdv), 0);
    repeat (LAT) tick();
    chk("rst_cfg_out0", outv(0), 0);
    chk_out("rst_model");
`ifdef DSP_ROUTE_SHADOW_EN
    set_src(0, 700);
    wr(16'h000, 32'h1);
    repeat (LAT) tick();
    chk("shadow_hold", outv(0), 0);
    rd(16'h200, rdv, rde);
    chk("shadow_act_rd", int'(rdv), 0);
    rd(16'h000, rdv, rde);
    chk("shadow_rd", int'(rdv), 1);
    wr(16'h104, 32'h1);
    repeat (LAT - 1) tick();
    chk("commit_early", outv(0), 0);
    tick();
    chk("commit_out0", outv(0), 700);
`endif
    for (int c = 0; c < 400; c++) begin
      amp = (c < 200) ? (1 << (DW-1)) : (1 << (DW-4));
      for (int s = 0; s < SRC; s++) set_src(s, int'($urandom_range(0, 2*amp - 1)) - amp);
      if (c % 7 == 0) cfg(int'($urandom_range(0, SRC-1)), $urandom);
      else if (c % 29 == 0) wr(16'h100, $urandom);
      else if (c % 13 == 0) begin
        want = int'(sticky_m);
        rd(16'h100, rdv, rde);
        chk("rand_sticky", int'(rdv), want);
      end else tick();
      chk_out("rand");
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
